vga_sync_gen: RTL and testbench

- Pixel-timing stage directly upstream of the VGA DAC pins in mariokart_top_level.
- Divides the 50 MHz system clock to a 25 MHz pixel rate and produces 640x480@60 Hz horizontal/vertical counters.
- Drives current-pixel coordinates and frame/line strobes to the renderer (glyph/sprite/background mux).
- Drives vga_clk, vga_hs, vga_vs and vga_blank_n, each delayed by a fixed number of pixels so they line up with the renderer's r/g/b output.

---
 rtl/vga_timing_pkg.sv | 21 ++
 rtl/vga_dly_line.sv | 33 +++
 rtl/vga_sync_gen.sv | 142 ++++++++++++++
 tb/tb_vga_sync_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz timing constants and coordinate type shared by the VGA sync generator.
package vga_timing_pkg;

    localparam int unsigned H_VIS  = 640;
    localparam int unsigned H_FP   = 16;
    localparam int unsigned H_SYNC = 96;
    localparam int unsigned H_BP   = 48;

    localparam int unsigned V_VIS  = 480;
    localparam int unsigned V_FP   = 10;
    localparam int unsigned V_SYNC = 2;
    localparam int unsigned V_BP   = 33;

    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int unsigned COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_dly_line.sv
// Pixel-enable gated shift register; a depth of 0 still yields one register stage.
module vga_dly_line #(
    parameter int unsigned      Width    = 3,
    parameter int unsigned      Depth    = 2,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    localparam int unsigned Stages = (Depth == 0) ? 1 : Depth;

    logic [Width-1:0] stage_q [Stages];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Stages; i++) begin
                stage_q[i] <= ResetVal;
            end
        end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < Stages; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[Stages-1];

endmodule

// File: rtl/vga_sync_gen.sv
// VGA pixel-rate divider, h/v counters and pipeline-aligned sync/blank outputs.
// Optional frame counter output enabled by defining VGA_SYNC_FRAME_CNT_EN.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned HVis    = H_VIS,
    parameter int unsigned HFp     = H_FP,
    parameter int unsigned HSync   = H_SYNC,
    parameter int unsigned HBp     = H_BP,
    parameter int unsigned VVis    = V_VIS,
    parameter int unsigned VFp     = V_FP,
    parameter int unsigned VSync   = V_SYNC,
    parameter int unsigned VBp     = V_BP,
    parameter int unsigned PipeDly = 2
) (
    input  logic               clock,
    input  logic               reset,
    output logic               pix_en,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               active,
    output logic               line_start,
    output logic               frame_start,
    output logic               vga_clk,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [7:0]         frame_cnt
`endif
);

    localparam int unsigned HTotal = HVis + HFp + HSync + HBp;
    localparam int unsigned VTotal = VVis + VFp + VSync + VBp;

    localparam coord_t HLast      = coord_t'(HTotal - 1);
    localparam coord_t VLast      = coord_t'(VTotal - 1);
    localparam coord_t HVisC      = coord_t'(HVis);
    localparam coord_t VVisC      = coord_t'(VVis);
    localparam coord_t HSyncFirst = coord_t'(HVis + HFp);
    localparam coord_t HSyncLast  = coord_t'(HVis + HFp + HSync - 1);
    localparam coord_t VSyncFirst = coord_t'(VVis + VFp);
    localparam coord_t VSyncLast  = coord_t'(VVis + VFp + VSync - 1);

    logic   phase_q, phase_d;
    logic   pix_en_q;
    logic   vga_clk_q;
    coord_t h_cnt_q, h_cnt_d;
    coord_t v_cnt_q, v_cnt_d;
    logic   line_start_q, line_start_d;
    logic   frame_start_q, frame_start_d;

    logic hs_raw, vs_raw, blank_n_raw;
    logic [2:0] dly_out;

    always_comb begin
        phase_d = ~phase_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en_q) begin
            if (h_cnt_q == HLast) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
        // Strobes are registered alongside pix_en; counters are stable on this edge.
        line_start_d  = phase_q && (h_cnt_q == '0);
        frame_start_d = line_start_d && (v_cnt_q == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q       <= 1'b0;
            pix_en_q      <= 1'b0;
            vga_clk_q     <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            pix_en_q      <= phase_q;
            vga_clk_q     <= phase_q;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign active      = (h_cnt_q < HVisC) && (v_cnt_q < VVisC);
    assign hs_raw      = !((h_cnt_q >= HSyncFirst) && (h_cnt_q <= HSyncLast));
    assign vs_raw      = !((v_cnt_q >= VSyncFirst) && (v_cnt_q <= VSyncLast));
    assign blank_n_raw = active;

    vga_dly_line #(
        .Width    (3),
        .Depth    (PipeDly),
        .ResetVal (3'b110)
    ) u_dly (
        .clk_i (clock),
        .rst_i (reset),
        .en_i  (pix_en_q),
        .d_i   ({hs_raw, vs_raw, blank_n_raw}),
        .q_o   (dly_out)
    );

    assign pix_en      = pix_en_q;
    assign x           = h_cnt_q;
    assign y           = v_cnt_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign vga_clk     = vga_clk_q;
    assign vga_hs      = dly_out[2];
    assign vga_vs      = dly_out[1];
    assign vga_blank_n = dly_out[0];

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_q) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full 640x480 timing on one instance, a tiny-timing instance for frame-level checks.
module tb_vga_sync_gen;

    logic       clock;
    logic       reset;

    logic       pix_en, active, line_start, frame_start, vga_clk, vga_hs, vga_vs, vga_blank_n;
    logic [9:0] x, y;

    logic       s_pix_en, s_active, s_line_start, s_frame_start, s_vga_clk;
    logic       s_vga_hs, s_vga_vs, s_vga_blank_n;
    logic [9:0] s_x, s_y;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] frame_cnt, s_frame_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    vga_sync_gen #(
        .PipeDly (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pix_en      (pix_en),
        .x           (x),
        .y           (y),
        .active      (active),
        .line_start  (line_start),
        .frame_start (frame_start),
        .vga_clk     (vga_clk),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n)
`ifdef VGA_SYNC_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    // 15 pixels x 8 lines, sync low at x=10..12 and y=5..6, single-stage delay.
    vga_sync_gen #(
        .HVis    (8),
        .HFp     (2),
        .HSync   (3),
        .HBp     (2),
        .VVis    (4),
        .VFp     (1),
        .VSync   (2),
        .VBp     (1),
        .PipeDly (0)
    ) dut_s (
        .clock       (clock),
        .reset       (reset),
        .pix_en      (s_pix_en),
        .x           (s_x),
        .y           (s_y),
        .active      (s_active),
        .line_start  (s_line_start),
        .frame_start (s_frame_start),
        .vga_clk     (s_vga_clk),
        .vga_hs      (s_vga_hs),
        .vga_vs      (s_vga_vs),
        .vga_blank_n (s_vga_blank_n)
`ifdef VGA_SYNC_FRAME_CNT_EN
        ,
        .frame_cnt   (s_frame_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0:       return line_start === 1'b1;
            1:       return vga_blank_n === 1'b1;
            2:       return vga_blank_n === 1'b0;
            3:       return vga_hs === 1'b0;
            4:       return vga_hs === 1'b1;
            5:       return s_frame_start === 1'b1;
            6:       return s_vga_vs === 1'b0;
            10:      return x === 10'd300;
            11:      return (s_x === 10'd14) && (s_y === 10'd7) && (s_pix_en === 1'b1);
            default: return 1'b0;
        endcase
    endfunction

    // Returns the number of clocks until the condition holds, or -1 on timeout.
    task automatic tick_until(input int sel, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (cond(sel)) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int cnt_b, cnt_v, cnt_h, first_fs, to_cnt;

        reset = 1'b1;
        repeat (4) tick();
        chk("rst_x",        32'(x), 0);
        chk("rst_y",        32'(y), 0);
        chk("rst_hs",       32'(vga_hs), 1);
        chk("rst_vs",       32'(vga_vs), 1);
        chk("rst_blank_n",  32'(vga_blank_n), 0);
        chk("rst_pix_en",   32'(pix_en), 0);
        chk("rst_vga_clk",  32'(vga_clk), 0);
        chk("rst_ls",       32'(line_start), 0);
        chk("rst_fs",       32'(frame_start), 0);
        chk("rst_s_hs",     32'(s_vga_hs), 1);
        chk("rst_s_vs",     32'(s_vga_vs), 1);
`ifdef VGA_SYNC_FRAME_CNT_EN
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
`endif

        reset = 1'b0;
        tick();
        chk("rel1_pix_en",  32'(pix_en), 0);
        chk("rel1_vga_clk", 32'(vga_clk), 0);
        tick();
        chk("rel2_pix_en",  32'(pix_en), 1);
        chk("rel2_vga_clk", 32'(vga_clk), 1);
        chk("rel2_fs",      32'(frame_start), 1);
        chk("rel2_ls",      32'(line_start), 1);
        chk("rel2_active",  32'(active), 1);
        chk("rel2_blank_n", 32'(vga_blank_n), 0);
        tick();
        chk("rel3_x",       32'(x), 1);
        chk("rel3_vga_clk", 32'(vga_clk), 0);
        chk("rel3_fs",      32'(frame_start), 0);

        // Line timing measured from the first line_start; counts are clocks.
        tick_until(1, 10, n);
        chk("blank_rise_clk", n, 2);
        chk("blank_rise_x",   32'(x), 2);
        tick_until(2, 2000, n);
        chk("blank_high_clks", n, 1280);
        chk("blank_fall_x",    32'(x), 642);
        tick_until(3, 2000, n);
        chk("hs_fall_clk", n, 32);
        chk("hs_fall_x",   32'(x), 658);
        tick_until(4, 2000, n);
        chk("hs_low_clks", n, 192);
        chk("hs_rise_x",   32'(x), 754);
        tick_until(0, 2000, n);
        chk("ls_rest_clks", n, 93);
        chk("ls_x",         32'(x), 0);
        chk("ls_y",         32'(y), 1);
        chk("ls_pix_en",    32'(pix_en), 1);

        // Frame-level checks on the small instance.
        tick_until(5, 300, n);
        chk("s_fs_sync_timeout", 32'(n < 0), 0);
        chk("s_fs_pos", 32'({s_x, s_y}), 0);
        cnt_b = 0;
        cnt_v = 0;
        cnt_h = 0;
        first_fs = -1;
        for (int i = 1; i <= 240; i++) begin
            tick();
            if (s_pix_en && s_vga_blank_n) cnt_b++;
            if (!s_vga_vs) cnt_v++;
            if (!s_vga_hs) cnt_h++;
            if (s_frame_start && first_fs < 0) first_fs = i;
        end
        chk("s_frame_period", first_fs, 240);
        chk("s_blank_pixels", cnt_b, 32);
        chk("s_vs_low_clks",  cnt_v, 60);
        chk("s_hs_low_clks",  cnt_h, 48);
        tick_until(6, 300, n);
        chk("s_vs_fall_y", 32'(s_y), 5);
        chk("s_vs_fall_x", 32'(s_x), 1);

        tick_until(11, 300, n);
        chk("s_wrap_found", 32'(n < 0), 0);
        tick();
        chk("s_wrap_x",  32'(s_x), 0);
        chk("s_wrap_y",  32'(s_y), 0);
        chk("s_wrap_fs_early", 32'(s_frame_start), 0);
        tick();
        chk("s_wrap_pix_en",  32'(s_pix_en), 1);
        chk("s_wrap_fs",      32'(s_frame_start), 1);
        chk("s_wrap_ls",      32'(s_line_start), 1);
        chk("s_wrap_active",  32'(s_active), 1);
        chk("s_wrap_vga_clk", 32'(s_vga_clk), 1);

        // Reset pulse in the middle of a visible line.
        tick_until(10, 2000, n);
        chk("mid_found",    32'(n < 0), 0);
        chk("mid_blank_pre", 32'(vga_blank_n), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_x",       32'(x), 0);
        chk("mid_y",       32'(y), 0);
        chk("mid_hs",      32'(vga_hs), 1);
        chk("mid_vs",      32'(vga_vs), 1);
        chk("mid_blank_n", 32'(vga_blank_n), 0);
        chk("mid_fs0",     32'(frame_start), 0);
        chk("mid_s_x",     32'(s_x), 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        chk("mid_frame_cnt", 32'(s_frame_cnt), 0);
`endif
        tick();
        chk("mid_fs1",     32'(frame_start), 0);
        chk("mid_pix_en1", 32'(pix_en), 0);
        tick();
        chk("mid_fs2",     32'(frame_start), 1);
        chk("mid_pix_en2", 32'(pix_en), 1);
        chk("mid_s_fs2",   32'(s_frame_start), 1);

`ifdef VGA_SYNC_FRAME_CNT_EN
        tick();
        chk("fcnt_1", 32'(s_frame_cnt), 1);
        to_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            tick_until(5, 300, n);
            if (n < 0) to_cnt++;
        end
        tick();
        chk("fcnt_3", 32'(s_frame_cnt), 3);
        for (int i = 0; i < 252; i++) begin
            tick_until(5, 300, n);
            if (n < 0) to_cnt++;
        end
        tick();
        chk("fcnt_255", 32'(s_frame_cnt), 255);
        tick_until(5, 300, n);
        if (n < 0) to_cnt++;
        tick();
        chk("fcnt_wrap", 32'(s_frame_cnt), 0);
        chk("fcnt_timeouts", to_cnt, 0);
`else
        to_cnt = 0;
        cnt_b = 0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
